mole_game_ctrl: RTL and testbench

//  Whack-a-mole game engine. Tracks the state of the 9 holes (3x3 grid, row-major, hole 0 top-left)
//  and turns button hits and pseudo-random spawns into the 18-bit hole map.

---
 rtl/mole_game_ctrl.sv | 156 +++++++++++++++
 tb/tb_mole_game_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game engine.
// Keeps nine hole states for a 3x3 grid and drives the 18-bit map used by
// the VGA display stage. Also tracks score and misses, and ends the game
// once too many moles expire.
//
// state | meaning
// IDLE  | after reset; map held at 0, hits ignored, waiting for start
// PLAY  | game running; ticks, spawns, hits and expiries are processed
// OVER  | miss limit reached; map/score/miss frozen until the next start
module mole_game_ctrl #(
    parameter int          TICK_DIV  = 5_000_000,
    parameter int          MOLE_LIFE = 16,
    parameter int          HIT_SHOW  = 6,
    parameter int          SPAWN_GAP = 8,
    parameter int          MAX_MISS  = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  hit,
    output logic [17:0] map,
    output logic [7:0]  score,
    output logic [7:0]  miss,
    output logic        game_over
);

    localparam int TW = $clog2(TICK_DIV);

    localparam logic [1:0] ST_EMPTY     = 2'b00;
    localparam logic [1:0] ST_MOLE      = 2'b01;
    localparam logic [1:0] ST_HIT_MOUSE = 2'b10;
    localparam logic [1:0] ST_HIT_EMPTY = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } fsm_t;

    fsm_t          state;
    logic [TW-1:0] tick_cnt;
    logic [4:0]    spawn_cnt;
    logic [15:0]   lfsr;
    logic [4:0]    timer [9];

    logic          tick;
    logic          spawn_now;
    logic [3:0]    idx;
    logic [15:0]   lfsr_nx;
    logic [17:0]   map_nx;
    logic [4:0]    timer_nx [9];
    logic [3:0]    n_hit;
    logic [3:0]    n_exp;
    logic [8:0]    score_sum;
    logic [8:0]    miss_sum;
    logic [7:0]    score_nx;
    logic [7:0]    miss_nx;

    assign tick      = (state == PLAY) && (tick_cnt == TW'(TICK_DIV - 1));
    assign spawn_now = tick && (spawn_cnt == 5'(SPAWN_GAP - 1));
    assign idx       = lfsr[3:0];
    // Galois form, taps 16,14,13,11
    assign lfsr_nx   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Next hole states/timers for one PLAY cycle: hit beats expiry, spawn only into an idle, unhit hole
    always_comb begin
        map_nx = map;
        n_hit  = 4'd0;
        n_exp  = 4'd0;
        for (int i = 0; i < 9; i++) begin
            timer_nx[i] = timer[i];
        end
        for (int i = 0; i < 9; i++) begin
            if (hit[i] && map[2*i +: 2] == ST_MOLE) begin
                map_nx[2*i +: 2] = ST_HIT_MOUSE;
                timer_nx[i]      = 5'(HIT_SHOW);
                n_hit            = n_hit + 4'd1;
            end else if (hit[i] && map[2*i +: 2] == ST_EMPTY) begin
                map_nx[2*i +: 2] = ST_HIT_EMPTY;
                timer_nx[i]      = 5'(HIT_SHOW);
            end else if (tick && map[2*i +: 2] != ST_EMPTY) begin
                if (timer[i] == 5'd1) begin
                    if (map[2*i +: 2] == ST_MOLE) begin
                        n_exp = n_exp + 4'd1;
                    end
                    map_nx[2*i +: 2] = ST_EMPTY;
                    timer_nx[i]      = 5'd0;
                end else begin
                    timer_nx[i] = timer[i] - 5'd1;
                end
            end
            if (spawn_now && idx == 4'(i) && !hit[i] && map[2*i +: 2] == ST_EMPTY) begin
                map_nx[2*i +: 2] = ST_MOLE;
                timer_nx[i]      = 5'(MOLE_LIFE);
            end
        end
        score_sum = {1'b0, score} + {5'd0, n_hit};
        miss_sum  = {1'b0, miss} + {5'd0, n_exp};
        score_nx  = score_sum[8] ? 8'hFF : score_sum[7:0];
        miss_nx   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end

    // Top FSM plus all game registers; entering PLAY wipes the board and both counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            map       <= '0;
            score     <= '0;
            miss      <= '0;
            game_over <= 1'b0;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
            lfsr      <= LFSR_SEED;
            for (int i = 0; i < 9; i++) begin
                timer[i] <= '0;
            end
        end else begin
            lfsr <= lfsr_nx;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= PLAY;
                        game_over <= 1'b0;
                        map       <= '0;
                        score     <= '0;
                        miss      <= '0;
                        tick_cnt  <= '0;
                        spawn_cnt <= '0;
                        for (int i = 0; i < 9; i++) begin
                            timer[i] <= '0;
                        end
                    end
                end
                PLAY: begin
                    tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                    if (tick) begin
                        spawn_cnt <= spawn_now ? 5'd0 : spawn_cnt + 5'd1;
                    end
                    map   <= map_nx;
                    score <= score_nx;
                    miss  <= miss_nx;
                    for (int i = 0; i < 9; i++) begin
                        timer[i] <= timer_nx[i];
                    end
                    if (miss_sum >= 9'(MAX_MISS)) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Testbench for mole_game_ctrl: a behavioural game model predicts every cycle,
// predictions are queued on stimulus and compared after the clock edge.
module tb_mole_game_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int MOLE_LIFE = 3;
    localparam int HIT_SHOW  = 2;
    localparam int SPAWN_GAP = 2;
    localparam int MAX_MISS  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  hit;
    logic [17:0] map;
    logic [7:0]  score;
    logic [7:0]  miss;
    logic        game_over;

    mole_game_ctrl #(
        .TICK_DIV (TICK_DIV),
        .MOLE_LIFE(MOLE_LIFE),
        .HIT_SHOW (HIT_SHOW),
        .SPAWN_GAP(SPAWN_GAP),
        .MAX_MISS (MAX_MISS),
        .LFSR_SEED(SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hit      (hit),
        .map      (map),
        .score    (score),
        .miss     (miss),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    // Free-running 10 ns clock
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (0 idle, 1 play, 2 over)
    int          m_state;
    logic [1:0]  m_hs [9];
    int          m_tm [9];
    int          m_score;
    int          m_miss;
    bit          m_go;
    int          m_tcnt;
    int          m_scnt;
    logic [15:0] m_lfsr;

    logic [34:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_board();
        for (int i = 0; i < 9; i++) begin
            m_hs[i] = 2'b00;
            m_tm[i] = 0;
        end
        m_score = 0;
        m_miss  = 0;
        m_go    = 1'b0;
        m_tcnt  = 0;
        m_scnt  = 0;
    endtask

    task automatic model_reset();
        model_clear_board();
        m_state = 0;
        m_lfsr  = SEED;
    endtask

    task automatic model_step(input logic st, input logic [8:0] h);
        logic [15:0] l_next;
        logic        fb;
        bit          tk;
        bit          sp;
        int          sidx;
        int          nh;
        int          ne;
        logic [1:0]  old [9];
        fb        = m_lfsr[0];
        l_next    = {fb, m_lfsr[15:1]};
        l_next[13] = l_next[13] ^ fb;
        l_next[12] = l_next[12] ^ fb;
        l_next[10] = l_next[10] ^ fb;
        if (m_state != 1) begin
            if (st) begin
                model_clear_board();
                m_state = 1;
            end
        end else begin
            tk     = (m_tcnt == TICK_DIV - 1);
            m_tcnt = tk ? 0 : m_tcnt + 1;
            sp     = 1'b0;
            if (tk) begin
                m_scnt++;
                if (m_scnt == SPAWN_GAP) begin
                    m_scnt = 0;
                    sp     = 1'b1;
                end
            end
            sidx = int'(m_lfsr[3:0]);
            for (int i = 0; i < 9; i++) old[i] = m_hs[i];
            nh = 0;
            ne = 0;
            for (int i = 0; i < 9; i++) begin
                if (h[i] && old[i] == 2'b01) begin
                    m_hs[i] = 2'b10;
                    m_tm[i] = HIT_SHOW;
                    nh++;
                end else if (h[i] && old[i] == 2'b00) begin
                    m_hs[i] = 2'b11;
                    m_tm[i] = HIT_SHOW;
                end else if (tk && old[i] != 2'b00) begin
                    m_tm[i]--;
                    if (m_tm[i] == 0) begin
                        if (old[i] == 2'b01) ne++;
                        m_hs[i] = 2'b00;
                    end
                end
            end
            if (sp && sidx < 9) begin
                if (old[sidx] == 2'b00 && !h[sidx]) begin
                    m_hs[sidx] = 2'b01;
                    m_tm[sidx] = MOLE_LIFE;
                end
            end
            m_score = (m_score + nh > 255) ? 255 : m_score + nh;
            m_miss  = (m_miss + ne > 255) ? 255 : m_miss + ne;
            if (m_miss >= MAX_MISS) begin
                m_state = 2;
                m_go    = 1'b1;
            end
        end
        m_lfsr = l_next;
    endtask

    function automatic logic [34:0] model_out();
        logic [17:0] mp;
        for (int i = 0; i < 9; i++) mp[2*i +: 2] = m_hs[i];
        return {mp, 8'(m_score), 8'(m_miss), m_go};
    endfunction

    function automatic int find_mole();
        for (int i = 0; i < 9; i++) begin
            if (m_hs[i] == 2'b01) return i;
        end
        return -1;
    endfunction

    // One clock: drive at negedge, queue the prediction, compare just after posedge
    task automatic cyc(input logic st, input logic [8:0] h);
        logic [34:0] e;
        @(negedge clk);
        start = st;
        hit   = h;
        model_step(st, h);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("cycle", {map, score, miss, game_over}, e);
        start = 1'b0;
        hit   = 9'd0;
    endtask

    // Mid-cycle async reset followed by a start
    task automatic fresh_game();
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        cyc(1'b1, 9'd0);
    endtask

    int          k;
    int          sc;
    bit          done;
    logic [34:0] frozen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        hit   = 9'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_map", map, 0);
        check("rst_score", score, 0);
        check("rst_miss", miss, 0);
        check("rst_over", game_over, 0);

        // Hits in IDLE are ignored
        repeat (4) cyc(1'b0, 9'h1FF);
        check("idle_map", map, 0);
        cyc(1'b1, 9'd0);

        // Wait for first mole, then whack it
        k = -1;
        for (int n = 0; n < 300 && k < 0; n++) begin
            k = find_mole();
            if (k < 0) cyc(1'b0, 9'd0);
        end
        check("t2_spawn_seen", k >= 0, 1);
        if (k >= 0) begin
            cyc(1'b0, 9'(1 << k));
            check("t2_hit_map", map[2*k +: 2], 2'b10);
            check("t2_score", score, 1);
            done = 1'b0;
            for (int n = 0; n < 2 * TICK_DIV && !done; n++) begin
                cyc(1'b0, 9'd0);
                if (map[2*k +: 2] == 2'b00) done = 1'b1;
            end
            check("t2_hit_clear", done, 1);
        end

        // Async reset with the game running and a mole up
        for (int n = 0; n < 300 && find_mole() < 0; n++) cyc(1'b0, 9'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("t1_map", map, 0);
        check("t1_score", score, 0);
        check("t1_miss", miss, 0);
        check("t1_over", game_over, 0);
        rst = 1'b0;

        // Hits after the reset are ignored (IDLE) until start
        repeat (3) cyc(1'b0, 9'h010);
        check("t1_idle_map", map, 0);

        // Hit on an empty hole
        cyc(1'b1, 9'd0);
        sc = m_score;
        cyc(1'b0, 9'h010);
        check("t3_hit_empty_map", map[9:8], 2'b11);
        check("t3_score", score, sc);
        done = 1'b0;
        for (int n = 0; n < 2 * TICK_DIV && !done; n++) begin
            cyc(1'b0, 9'd0);
            if (map[9:8] == 2'b00) done = 1'b1;
        end
        check("t3_clear", done, 1);

        // Hit a mole on the exact cycle it would expire
        fresh_game();
        done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            if (m_state == 2) cyc(1'b1, 9'd0);
            k = -1;
            if (m_tcnt == TICK_DIV - 1) begin
                for (int i = 0; i < 9; i++) begin
                    if (k < 0 && m_hs[i] == 2'b01 && m_tm[i] == 1) k = i;
                end
            end
            if (k >= 0) begin
                sc = m_score;
                cyc(1'b0, 9'(1 << k));
                check("t5_map", map[2*k +: 2], 2'b10);
                check("t5_score", score, sc + 1);
                check("t5_miss", miss, m_miss);
                done = 1'b1;
            end else begin
                cyc(1'b0, 9'd0);
            end
        end
        check("t5_found", done, 1);

        // No hits until the game ends, then hits are frozen out
        fresh_game();
        for (int n = 0; n < 2000 && !game_over; n++) cyc(1'b0, 9'd0);
        check("t4_game_over", game_over, 1);
        check("t4_miss_limit", miss >= 8'(MAX_MISS), 1);
        frozen = model_out();
        repeat (6) cyc(1'b0, 9'h1FF);
        check("t4_frozen", {map, score, miss, game_over}, frozen);

        // Restart from OVER
        cyc(1'b1, 9'd0);
        check("t6_over", game_over, 0);
        check("t6_score", score, 0);
        check("t6_miss", miss, 0);
        check("t6_map", map, 0);
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            cyc(1'b0, 9'd0);
            for (int i = 0; i < 9; i++) if (map[2*i +: 2] == 2'b01) done = 1'b1;
        end
        check("t6_spawn", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
